// File: rtl/vector_acc_seq_if.sv
// Memory-side bus for vector_acc_seq: a read request/response channel and a
// single-beat result write channel. The accelerator is the master.
interface vector_acc_seq_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_rsp_valid;
  logic [DATA_WIDTH-1:0] rd_rsp_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output rd_req_valid,
    input  rd_req_ready,
    output rd_req_addr,
    input  rd_rsp_valid,
    input  rd_rsp_data,
    output wr_valid,
    input  wr_ready,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rd_req_valid,
    output rd_req_ready,
    input  rd_req_addr,
    output rd_rsp_valid,
    output rd_rsp_data,
    input  wr_valid,
    output wr_ready,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/vector_acc_seq.sv
// Sequential signed dot-product engine: fetches A[i] and B[i] one read at a
// time, accumulates A*B into a wrapping accumulator and writes the low word of
// the sum to dst. One outstanding read at most; abortable at any point.
module vector_acc_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH  = 48
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [ADDR_WIDTH-1:0] cfg_src_a,
  input  logic [ADDR_WIDTH-1:0] cfg_src_b,
  input  logic [ADDR_WIDTH-1:0] cfg_dst,
  input  logic                  cfg_irq_en,
  input  logic                  cfg_done_clr,
  vector_acc_seq_if.master      mem,
  output logic                  status_busy,
  output logic                  status_done,
  output logic                  status_err,
  output logic                  irq,
  output logic [ACC_WIDTH-1:0]  result
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StReqA   = 3'd1;
  localparam logic [2:0] StWaitA  = 3'd2;
  localparam logic [2:0] StReqB   = 3'd3;
  localparam logic [2:0] StWaitB  = 3'd4;
  localparam logic [2:0] StMac    = 3'd5;
  localparam logic [2:0] StWrite  = 3'd6;
  localparam logic [2:0] StFinish = 3'd7;

  logic [2:0]            state_q, state_d;
  logic                  abort_q, abort_d;
  logic [LEN_WIDTH-1:0]  len_q, idx_q, idx_inc;
  logic [ADDR_WIDTH-1:0] src_a_q, src_b_q, dst_q;
  logic                  irq_en_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [ACC_WIDTH-1:0]  acc_q, result_q;
  logic                  done_q, err_q;
  logic signed [ACC_WIDTH-1:0] a_ext, b_ext, prod;
  logic idle, start_ok, zero_len, abort_evt, done_set, rd_hs, wr_hs, abort_any;

  assign idle      = (state_q == StIdle);
  assign start_ok  = idle && cfg_start && (cfg_len != '0);
  assign zero_len  = idle && cfg_start && (cfg_len == '0);
  assign abort_evt = !idle && cfg_abort;
  // An abort in FINISH suppresses the done/result update of that cycle.
  assign done_set  = (state_q == StFinish) && !cfg_abort;
  assign rd_hs     = mem.rd_req_valid && mem.rd_req_ready;
  assign wr_hs     = mem.wr_valid && mem.wr_ready;
  assign abort_any = abort_q || cfg_abort;
  assign idx_inc   = idx_q + LEN_WIDTH'(1);

  // Products only matter modulo 2^ACC_WIDTH, so sign-extend and multiply there.
  always_comb begin
    a_ext = ACC_WIDTH'($signed(a_q));
    b_ext = ACC_WIDTH'($signed(b_q));
    prod  = a_ext * b_ext;
  end

  // Next-state logic; a pending abort in a request state waits for its handshake.
  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    unique case (state_q)
      StIdle:   if (start_ok) state_d = StReqA;
      StReqA: begin
        if (rd_hs)          state_d = abort_any ? StIdle : StWaitA;
        else if (cfg_abort) abort_d = 1'b1;
      end
      StWaitA: begin
        if (cfg_abort)             state_d = StIdle;
        else if (mem.rd_rsp_valid) state_d = StReqB;
      end
      StReqB: begin
        if (rd_hs)          state_d = abort_any ? StIdle : StWaitB;
        else if (cfg_abort) abort_d = 1'b1;
      end
      StWaitB: begin
        if (cfg_abort)             state_d = StIdle;
        else if (mem.rd_rsp_valid) state_d = StMac;
      end
      StMac: begin
        if (cfg_abort)            state_d = StIdle;
        else if (idx_inc < len_q) state_d = StReqA;
        else                      state_d = StWrite;
      end
      StWrite: begin
        if (wr_hs)          state_d = abort_any ? StIdle : StFinish;
        else if (cfg_abort) abort_d = 1'b1;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (state_d == StIdle) abort_d = 1'b0;
  end

  // FSM state and pending-abort flag.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= StIdle;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  // Datapath: config latch, operand capture, MAC and result update.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      len_q    <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      irq_en_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      if (start_ok) begin
        len_q    <= cfg_len;
        src_a_q  <= cfg_src_a;
        src_b_q  <= cfg_src_b;
        dst_q    <= cfg_dst;
        irq_en_q <= cfg_irq_en;
        acc_q    <= '0;
        idx_q    <= '0;
      end
      if ((state_q == StWaitA) && mem.rd_rsp_valid && !cfg_abort) a_q <= mem.rd_rsp_data;
      if ((state_q == StWaitB) && mem.rd_rsp_valid && !cfg_abort) b_q <= mem.rd_rsp_data;
      if ((state_q == StMac) && !cfg_abort) begin
        acc_q <= acc_q + $unsigned(prod);
        idx_q <= idx_inc;
      end
      if (done_set) result_q <= acc_q;
    end
  end

  // Sticky status; a same-cycle set beats cfg_done_clr.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (done_set)                      done_q <= 1'b1;
      else if (start_ok || cfg_done_clr) done_q <= 1'b0;
      if (abort_evt || zero_len)         err_q  <= 1'b1;
      else if (start_ok || cfg_done_clr) err_q  <= 1'b0;
    end
  end

  assign mem.rd_req_valid = (state_q == StReqA) || (state_q == StReqB);
  assign mem.rd_req_addr  = ((state_q == StReqB) ? src_b_q : src_a_q)
                          + (ADDR_WIDTH'(idx_q) << 2);
  assign mem.wr_valid     = (state_q == StWrite);
  assign mem.wr_addr      = dst_q;
  assign mem.wr_data      = acc_q[DATA_WIDTH-1:0];

  assign status_busy = !idle;
  assign status_done = done_q;
  assign status_err  = err_q;
  assign irq         = done_q && irq_en_q;
  assign result      = result_q;

endmodule

// File: tb/tb_vector_acc_seq.sv
// Directed bench for vector_acc_seq with a small memory responder that can
// stall requests, drop one response and inject a stray response.
module tb_vector_acc_seq;

  logic        ACLK;
  logic        ARESETN;
  logic        cfg_start, cfg_abort, cfg_irq_en, cfg_done_clr;
  logic [15:0] cfg_len;
  logic [31:0] cfg_src_a, cfg_src_b, cfg_dst;
  logic        status_busy, status_done, status_err, irq;
  logic [47:0] result;

  vector_acc_seq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

  vector_acc_seq #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .LEN_WIDTH (16),
    .ACC_WIDTH (48)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .cfg_start   (cfg_start),
    .cfg_abort   (cfg_abort),
    .cfg_len     (cfg_len),
    .cfg_src_a   (cfg_src_a),
    .cfg_src_b   (cfg_src_b),
    .cfg_dst     (cfg_dst),
    .cfg_irq_en  (cfg_irq_en),
    .cfg_done_clr(cfg_done_clr),
    .mem         (mem_if),
    .status_busy (status_busy),
    .status_done (status_done),
    .status_err  (status_err),
    .irq         (irq),
    .result      (result)
  );

  int total = 0;
  int bad   = 0;

  // Responder controls (written by the main thread only).
  int          bp          = 0;
  logic        wr_ready_en = 1'b1;
  logic        inject      = 1'b0;
  logic [31:0] drop_addr   = 32'hFFFF_FFFF;
  logic [31:0] mem_arr [logic [31:0]];

  // Responder observations (written by the responder only).
  logic [31:0] rd_log [$];
  logic [31:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  int          stab_bad = 0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  task automatic start_run(input logic [15:0] len, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] d);
    cfg_len   = len;
    cfg_src_a = a;
    cfg_src_b = b;
    cfg_dst   = d;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (status_busy && cyc < 3000);
    check_eq("run_timeout", {63'd0, status_busy}, 64'd0);
  endtask

  // Memory responder: samples handshakes mid-cycle, answers one cycle later.
  initial begin
    logic        hs, whs, pend_rd, pend_wr;
    logic [31:0] hs_addr, pend_addr, pend_waddr, pend_wdata;
    int          rd_wait, wr_wait;
    pend_rd = 1'b0;
    pend_wr = 1'b0;
    rd_wait = 0;
    wr_wait = 0;
    mem_if.rd_req_ready = 1'b0;
    mem_if.rd_rsp_valid = 1'b0;
    mem_if.rd_rsp_data  = '0;
    mem_if.wr_ready     = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        pend_rd = 1'b0;
        pend_wr = 1'b0;
        hs      = 1'b0;
        whs     = 1'b0;
        hs_addr = '0;
      end else begin
        if (pend_rd && (!mem_if.rd_req_valid || mem_if.rd_req_addr != pend_addr)) stab_bad++;
        if (pend_wr && (!mem_if.wr_valid || mem_if.wr_addr != pend_waddr ||
                        mem_if.wr_data != pend_wdata)) stab_bad++;
        hs         = mem_if.rd_req_valid && mem_if.rd_req_ready;
        hs_addr    = mem_if.rd_req_addr;
        pend_rd    = mem_if.rd_req_valid && !mem_if.rd_req_ready;
        pend_addr  = mem_if.rd_req_addr;
        whs        = mem_if.wr_valid && mem_if.wr_ready;
        pend_wr    = mem_if.wr_valid && !mem_if.wr_ready;
        pend_waddr = mem_if.wr_addr;
        pend_wdata = mem_if.wr_data;
        if (whs) begin
          wr_addr_log.push_back(mem_if.wr_addr);
          wr_data_log.push_back(mem_if.wr_data);
        end
      end
      @(posedge ACLK);
      #1;
      if (hs) rd_log.push_back(hs_addr);
      mem_if.rd_rsp_valid = (hs && hs_addr != drop_addr) || inject;
      mem_if.rd_rsp_data  = inject ? 32'hDEAD_BEEF : (hs ? mem_arr[hs_addr] : 32'd0);
      if (mem_if.rd_req_valid) begin
        if (rd_wait >= bp) mem_if.rd_req_ready = 1'b1;
        else begin
          mem_if.rd_req_ready = 1'b0;
          rd_wait++;
        end
      end else begin
        mem_if.rd_req_ready = 1'b0;
        rd_wait = 0;
      end
      if (mem_if.wr_valid) begin
        if (wr_ready_en && wr_wait >= bp) mem_if.wr_ready = 1'b1;
        else begin
          mem_if.wr_ready = 1'b0;
          wr_wait++;
        end
      end else begin
        mem_if.wr_ready = 1'b0;
        wr_wait = 0;
      end
    end
  end

  initial begin
    int rb, wb, cyc, n;
    logic busy_seen;
    logic [31:0] exp_addr;

    ARESETN      = 1'b0;
    cfg_start    = 1'b0;
    cfg_abort    = 1'b0;
    cfg_irq_en   = 1'b1;
    cfg_done_clr = 1'b0;
    cfg_len      = '0;
    cfg_src_a    = '0;
    cfg_src_b    = '0;
    cfg_dst      = '0;
    for (int i = 0; i < 8; i++) begin
      mem_arr[32'h1000 + 4 * i] = (i < 4) ? i + 1 : 0;
      mem_arr[32'h2000 + 4 * i] = (i < 4) ? i + 5 : 0;
      mem_arr[32'h7000 + 4 * i] = i + 1;
      mem_arr[32'h8000 + 4 * i] = i + 1;
    end
    mem_arr[32'h4000] = 32'hFFFF_FFFD;
    mem_arr[32'h4004] = 32'h7FFF_FFFF;
    mem_arr[32'h5000] = 32'd4;
    mem_arr[32'h5004] = 32'd2;

    // Reset state, then release with no request on the release edge.
    repeat (3) tick();
    check_eq("rst_busy", {63'd0, status_busy}, 64'd0);
    check_eq("rst_rd_valid", {63'd0, mem_if.rd_req_valid}, 64'd0);
    ARESETN = 1'b1;
    tick();
    check_eq("rel_rd_valid", {63'd0, mem_if.rd_req_valid}, 64'd0);
    check_eq("rel_status", {60'd0, status_busy, status_done, status_err, irq}, 64'd0);
    check_eq("rel_result", {16'd0, result}, 64'd0);

    // Basic dot product, zero-wait memory: 70, 22 cycles start-to-idle.
    rb = rd_log.size();
    wb = wr_addr_log.size();
    start_run(16'd4, 32'h1000, 32'h2000, 32'h3000);
    check_eq("first_rd_valid", {63'd0, mem_if.rd_req_valid}, 64'd1);
    wait_idle(cyc);
    check_eq("latency", 64'(cyc), 64'd22);
    check_eq("basic_nreads", 64'(rd_log.size() - rb), 64'd8);
    for (int i = 0; i < 8; i++) begin
      exp_addr = ((i % 2) == 0) ? 32'h1000 + 4 * (i / 2) : 32'h2000 + 4 * (i / 2);
      if (rb + i < rd_log.size()) check_eq("basic_rd_addr", {32'd0, rd_log[rb + i]}, {32'd0, exp_addr});
    end
    check_eq("basic_nwrites", 64'(wr_addr_log.size() - wb), 64'd1);
    if (wb < wr_addr_log.size()) begin
      check_eq("basic_wr_addr", {32'd0, wr_addr_log[wb]}, 64'h3000);
      check_eq("basic_wr_data", {32'd0, wr_data_log[wb]}, 64'd70);
    end
    check_eq("basic_result", {16'd0, result}, 64'd70);
    check_eq("basic_done_irq_err", {61'd0, status_done, irq, status_err}, 64'b110);

    cfg_done_clr = 1'b1;
    tick();
    cfg_done_clr = 1'b0;
    check_eq("clr_done_irq", {62'd0, status_done, irq}, 64'd0);

    // Signed math with wrap into 48 bits.
    wb = wr_addr_log.size();
    start_run(16'd2, 32'h4000, 32'h5000, 32'h6000);
    wait_idle(cyc);
    check_eq("signed_result", {16'd0, result}, 64'h0000_FFFF_FFF2);
    if (wb < wr_data_log.size()) check_eq("signed_wr_data", {32'd0, wr_data_log[wb]}, 64'hFFFF_FFF2);
    else check_eq("signed_nwrites", 64'(wr_data_log.size() - wb), 64'd1);

    // Backpressure of 3 cycles on every request and on the write.
    bp = 3;
    rb = rd_log.size();
    wb = wr_addr_log.size();
    start_run(16'd4, 32'h1000, 32'h2000, 32'h3000);
    wait_idle(cyc);
    bp = 0;
    check_eq("bp_result", {16'd0, result}, 64'd70);
    check_eq("bp_nreads", 64'(rd_log.size() - rb), 64'd8);
    if (wb < wr_data_log.size()) check_eq("bp_wr_data", {32'd0, wr_data_log[wb]}, 64'd70);
    else check_eq("bp_nwrites", 64'(wr_data_log.size() - wb), 64'd1);
    check_eq("bp_stable", 64'(stab_bad), 64'd0);

    // Zero length, with done_clr in the same cycle: err set wins, done cleared.
    rb = rd_log.size();
    wb = wr_addr_log.size();
    busy_seen    = 1'b0;
    cfg_len      = '0;
    cfg_start    = 1'b1;
    cfg_done_clr = 1'b1;
    tick();
    cfg_start    = 1'b0;
    cfg_done_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      busy_seen = busy_seen | status_busy | mem_if.rd_req_valid | mem_if.wr_valid;
      tick();
    end
    check_eq("zl_err", {63'd0, status_err}, 64'd1);
    check_eq("zl_done", {63'd0, status_done}, 64'd0);
    check_eq("zl_busy_seen", {63'd0, busy_seen}, 64'd0);
    check_eq("zl_traffic", 64'(rd_log.size() - rb + wr_addr_log.size() - wb), 64'd0);

    // Abort in WAIT_B of element 2 (its B response withheld), then a stray response.
    drop_addr = 32'h8008;
    rb = rd_log.size();
    wb = wr_addr_log.size();
    start_run(16'd8, 32'h7000, 32'h8000, 32'h9000);
    n = 0;
    while ((rd_log.size() - rb) < 6 && n < 300) begin
      tick();
      n++;
    end
    check_eq("ab_reads_before", 64'(rd_log.size() - rb), 64'd6);
    check_eq("ab_in_wait", {62'd0, status_busy, mem_if.rd_req_valid}, 64'b10);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check_eq("ab_idle", {63'd0, status_busy}, 64'd0);
    check_eq("ab_err_done", {62'd0, status_err, status_done}, 64'b10);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (5) tick();
    check_eq("ab_still_idle", {63'd0, status_busy}, 64'd0);
    check_eq("ab_reads_after", 64'(rd_log.size() - rb), 64'd6);
    check_eq("ab_no_write", 64'(wr_addr_log.size() - wb), 64'd0);
    check_eq("ab_result_kept", {16'd0, result}, 64'd70);
    drop_addr = 32'hFFFF_FFFF;

    wb = wr_addr_log.size();
    start_run(16'd2, 32'h4000, 32'h5000, 32'h6000);
    wait_idle(cyc);
    check_eq("post_ab_result", {16'd0, result}, 64'h0000_FFFF_FFF2);
    check_eq("post_ab_status", {62'd0, status_done, status_err}, 64'b10);
    check_eq("post_ab_nwrites", 64'(wr_addr_log.size() - wb), 64'd1);

    // Reset while stuck in WRITE.
    wr_ready_en = 1'b0;
    start_run(16'd1, 32'h1000, 32'h2000, 32'h3000);
    n = 0;
    while (!mem_if.wr_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("rw_in_write", {63'd0, mem_if.wr_valid}, 64'd1);
    ARESETN = 1'b0;
    #1;
    check_eq("rw_wr_valid_drop", {63'd0, mem_if.wr_valid}, 64'd0);
    check_eq("rw_status", {60'd0, status_busy, status_done, status_err, irq}, 64'd0);
    check_eq("rw_result", {16'd0, result}, 64'd0);
    repeat (2) tick();
    ARESETN = 1'b1;
    tick();
    wr_ready_en = 1'b1;
    check_eq("rw_after_status", {60'd0, status_busy, status_done, status_err, irq}, 64'd0);
    check_eq("rw_after_valid", {62'd0, mem_if.rd_req_valid, mem_if.wr_valid}, 64'd0);
    check_eq("all_stable", 64'(stab_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
